// File: rtl/bf16_pkg.sv
// Shared bfloat16 definitions: word layout, operand classes and constants.
// Used by the multiplier pipeline now and by the adder rework later.
package bf16_pkg;

    localparam int EXP_W  = 8;
    localparam int MAN_W  = 7;
    localparam int WORD_W = 1 + EXP_W + MAN_W;

    localparam int                BF16_BIAS    = 127;
    localparam logic [WORD_W-1:0] BF16_QNAN    = 16'h7FC0;
    localparam logic [EXP_W-1:0]  BF16_EXP_MAX = 8'hFF;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } bf16_t;

    typedef enum logic [1:0] {ZERO, NORM, INF, NAN} bf16_class_e;

    // Subnormals are flushed, so any zero exponent counts as zero.
    function automatic bf16_class_e bf16_classify(input bf16_t x);
        if (x.exp == '0)
            return ZERO;
        else if (x.exp == BF16_EXP_MAX)
            return (x.man == '0) ? INF : NAN;
        else
            return NORM;
    endfunction

endpackage

// File: rtl/bf16_mul_pipe_if.sv
// Valid/ready operand and result stream of the bf16 multiplier.
// master = the side feeding operands and consuming products; slave = multiplier.
interface bf16_mul_pipe_if;
    import bf16_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] c;
    logic [2:0]        flags;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c, flags
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c, flags
    );

endinterface

// File: rtl/bf16_round_pack.sv
// Combinational normalize/round/pack of a raw 8x8 significand product.
// BF16_MUL_RNE_EN selects round-to-nearest-even; otherwise the result is truncated.
module bf16_round_pack
    import bf16_pkg::*;
(
    input  logic               sign,
    input  logic signed [9:0]  esum,
    input  logic [15:0]        p,
    output logic [WORD_W-1:0]  c,
    output logic               overflow,
    output logic               underflow
);

    logic [MAN_W-1:0] man_n;
    logic [MAN_W-1:0] man_r;
    logic signed [9:0] exp_n;
    logic signed [9:0] exp_r;

`ifdef BF16_MUL_RNE_EN
    logic       guard;
    logic       sticky;
    logic       round_up;
    logic [7:0] man_sum;
`endif

    // Pick the mantissa window depending on whether the product reached 2.0.
    always_comb begin
        man_n = p[13:7];
        exp_n = esum;
`ifdef BF16_MUL_RNE_EN
        guard  = p[6];
        sticky = |p[5:0];
`endif
        if (p[15]) begin
            man_n = p[14:8];
            exp_n = esum + 10'sd1;
`ifdef BF16_MUL_RNE_EN
            guard  = p[7];
            sticky = |p[6:0];
`endif
        end
    end

`ifdef BF16_MUL_RNE_EN
    // Round half to even; a carry out of the mantissa bumps the exponent.
    always_comb begin
        round_up = guard && (sticky || man_n[0]);
        man_sum  = {1'b0, man_n} + {7'b0, round_up};
        man_r    = man_sum[6:0];
        exp_r    = exp_n;
        if (man_sum[7]) begin
            man_r = '0;
            exp_r = exp_n + 10'sd1;
        end
    end
`else
    assign man_r = man_n;
    assign exp_r = exp_n;
`endif

    // Saturate to infinity or flush to zero when the exponent leaves the normal range.
    always_comb begin
        c         = {sign, exp_r[7:0], man_r};
        overflow  = 1'b0;
        underflow = 1'b0;
        if (exp_r >= 10'sd255) begin
            c        = {sign, BF16_EXP_MAX, 7'h00};
            overflow = 1'b1;
        end else if (exp_r <= 10'sd0) begin
            c         = {sign, 15'h0000};
            underflow = 1'b1;
        end
    end

endmodule

// File: rtl/bf16_mul_pipe.sv
// Three-stage bfloat16 multiplier with a global valid/ready stall.
// Stages: unpack/classify, 8x8 multiply, normalize/round/pack into the output register.
// Rounding mode comes from BF16_MUL_RNE_EN (see bf16_round_pack).
module bf16_mul_pipe
    import bf16_pkg::*;
(
    input logic              clk,
    input logic              rst_n,
    bf16_mul_pipe_if.slave   bus
);

    localparam logic signed [9:0] ESUM_BIAS = 10'(BF16_BIAS);

    bf16_t op_a;
    bf16_t op_b;
    logic  adv;

    logic              v1;
    logic              sign1;
    bf16_class_e       cls_a1;
    bf16_class_e       cls_b1;
    logic signed [9:0] esum1;
    logic [7:0]        sig_a1;
    logic [7:0]        sig_b1;

    logic              v2;
    logic              sign2;
    bf16_class_e       cls_a2;
    bf16_class_e       cls_b2;
    logic signed [9:0] esum2;
    logic [15:0]       prod2;

    logic [WORD_W-1:0] rp_c;
    logic              rp_ovf;
    logic              rp_unf;
    logic              any_nan;
    logic              any_inf;
    logic              any_zero;
    logic [WORD_W-1:0] res_c;
    logic [2:0]        res_flags;

    logic              out_valid_q;
    logic [WORD_W-1:0] c_q;
    logic [2:0]        flags_q;

    assign op_a          = bus.a;
    assign op_b          = bus.b;
    assign adv           = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.c         = c_q;
    assign bus.flags     = flags_q;

    // Stage 1: register sign, operand classes, biased exponent sum and significands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            sign1  <= 1'b0;
            cls_a1 <= ZERO;
            cls_b1 <= ZERO;
            esum1  <= '0;
            sig_a1 <= '0;
            sig_b1 <= '0;
        end else if (adv) begin
            v1     <= bus.in_valid;
            sign1  <= op_a.sign ^ op_b.sign;
            cls_a1 <= bf16_classify(op_a);
            cls_b1 <= bf16_classify(op_b);
            esum1  <= $signed({2'b00, op_a.exp}) + $signed({2'b00, op_b.exp}) - ESUM_BIAS;
            sig_a1 <= {1'b1, op_a.man};
            sig_b1 <= {1'b1, op_b.man};
        end
    end

    // Stage 2: full significand product, with class/sign/exponent carried alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2     <= 1'b0;
            sign2  <= 1'b0;
            cls_a2 <= ZERO;
            cls_b2 <= ZERO;
            esum2  <= '0;
            prod2  <= '0;
        end else if (adv) begin
            v2     <= v1;
            sign2  <= sign1;
            cls_a2 <= cls_a1;
            cls_b2 <= cls_b1;
            esum2  <= esum1;
            prod2  <= sig_a1 * sig_b1;
        end
    end

    bf16_round_pack u_round_pack (
        .sign      (sign2),
        .esum      (esum2),
        .p         (prod2),
        .c         (rp_c),
        .overflow  (rp_ovf),
        .underflow (rp_unf)
    );

    assign any_nan  = (cls_a2 == NAN)  || (cls_b2 == NAN);
    assign any_inf  = (cls_a2 == INF)  || (cls_b2 == INF);
    assign any_zero = (cls_a2 == ZERO) || (cls_b2 == ZERO);

    // Special operands override the arithmetic result and its range flags.
    always_comb begin
        res_c     = rp_c;
        res_flags = {1'b0, rp_ovf, rp_unf};
        if (any_nan || (any_inf && any_zero)) begin
            res_c     = BF16_QNAN;
            res_flags = 3'b100;
        end else if (any_inf) begin
            res_c     = {sign2, BF16_EXP_MAX, 7'h00};
            res_flags = 3'b000;
        end else if (any_zero) begin
            res_c     = {sign2, 15'h0000};
            res_flags = 3'b000;
        end
    end

    // Stage 3: output register, held while the consumer stalls; bubbles leave c untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            c_q         <= '0;
            flags_q     <= '0;
        end else if (adv) begin
            out_valid_q <= v2;
            if (v2) begin
                c_q     <= res_c;
                flags_q <= res_flags;
            end
        end
    end

endmodule

// File: tb/tb_bf16_mul_pipe.sv
// Self-checking bench for bf16_mul_pipe: scoreboard of expected {c, flags}
// filled as operands are accepted and drained by a monitor on each handshake.
module tb_bf16_mul_pipe;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    bf16_mul_pipe_if bus ();

    bf16_mul_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

`ifdef BF16_MUL_RNE_EN
    localparam logic [15:0] C_3FC1_SQ = 16'h4012;
`else
    localparam logic [15:0] C_3FC1_SQ = 16'h4011;
`endif

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          n_out        = 0;
    logic [18:0] sb[$];
    logic [18:0] mon_exp;

    // Monitor: every accepted output is compared with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            tests_run++;
            n_out++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL unexpected_output: got c=%h flags=%b, required no output", bus.c, bus.flags);
            end else begin
                mon_exp = sb.pop_front();
                if ({bus.c, bus.flags} !== mon_exp)
                begin
                    tests_failed++;
                    $display("[TB] FAIL result: got c=%h flags=%b, required c=%h flags=%b",
                             bus.c, bus.flags, mon_exp[18:3], mon_exp[2:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Offer one operand pair (starting just after a rising edge) until accepted.
    task automatic send(input logic [15:0] va, input logic [15:0] vb,
                        input logic [15:0] ec, input logic [2:0] ef);
        int waited = 0;
        bus.a        = va;
        bus.b        = vb;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (bus.in_ready !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL send_timeout: in_ready=%b, required 1", bus.in_ready);
        end else begin
            sb.push_back({ec, ef});
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Count edges from the transfer edge until out_valid rises.
    task automatic measure_latency(input string name);
        int cyc = 1;
        while (bus.out_valid !== 1'b1 && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        tests_run++;
        if (cyc != 3) begin
            tests_failed++;
            $display("[TB] FAIL latency_%s: got %0d cycles, required 3", name, cyc);
        end
    endtask

    // Wait for the scoreboard to empty, bounded.
    task automatic drain(input string name);
        int k = 0;
        while (sb.size() != 0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL drain_%s: got %0d results missing, required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        #12;
        tests_run += 3;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_out_valid: got %b, required 0", bus.out_valid);
        end
        if (bus.c !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_c: got %h, required 0000", bus.c);
        end
        if (bus.flags !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got %b, required 000", bus.flags);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_in_ready: got %b, required 1", bus.in_ready);
        end
    endtask

    task automatic test_vectors();
        logic [15:0] va[11];
        logic [15:0] vb[11];
        logic [15:0] vc[11];
        logic [2:0]  vf[11];
        va = '{16'h3FB9, 16'h3FC1, 16'hBF80, 16'h7F80, 16'h7F00, 16'h0080,
               16'h8000, 16'h7F80, 16'h7FC1, 16'h0000, 16'h3FB9};
        vb = '{16'h3FA2, 16'h3FC1, 16'h4000, 16'h0000, 16'h7F00, 16'h0080,
               16'h3F80, 16'hBF80, 16'h3F80, 16'h7F80, 16'hBFA2};
        vc = '{16'h3FEA, C_3FC1_SQ, 16'hC000, 16'h7FC0, 16'h7F80, 16'h0000,
               16'h8000, 16'hFF80, 16'h7FC0, 16'h7FC0, 16'hBFEA};
        vf = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b010, 3'b001,
               3'b000, 3'b000, 3'b100, 3'b100, 3'b000};
        for (int i = 0; i < 11; i++) begin
            send(va[i], vb[i], vc[i], vf[i]);
            measure_latency($sformatf("vec%0d", i));
            drain($sformatf("vec%0d", i));
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] va[6];
        logic [15:0] vb[6];
        logic [15:0] vc[6];
        logic [2:0]  vf[6];
        logic [15:0] held_c;
        int          n0;
        va = '{16'h3FB9, 16'hBF80, 16'h7F80, 16'h7F00, 16'h0080, 16'h3FC1};
        vb = '{16'h3FA2, 16'h4000, 16'h0000, 16'h7F00, 16'h0080, 16'h3FC1};
        vc = '{16'h3FEA, 16'hC000, 16'h7FC0, 16'h7F80, 16'h0000, C_3FC1_SQ};
        vf = '{3'b000, 3'b000, 3'b100, 3'b010, 3'b001, 3'b000};
        n0 = n_out;
        held_c = '0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(va[i], vb[i], vc[i], vf[i]);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    tests_run += 2;
                    if (bus.in_ready !== 1'b0) begin
                        tests_failed++;
                        $display("[TB] FAIL stall_in_ready_c%0d: got %b, required 0", k + 4, bus.in_ready);
                    end
                    if (k == 0) begin
                        held_c = bus.c;
                        if (bus.out_valid !== 1'b1) begin
                            tests_failed++;
                            $display("[TB] FAIL stall_out_valid: got %b, required 1", bus.out_valid);
                        end
                    end else if (bus.c !== held_c) begin
                        tests_failed++;
                        $display("[TB] FAIL stall_c_hold_c%0d: got %h, required %h", k + 4, bus.c, held_c);
                    end
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain("stream");
        tests_run++;
        if (n_out - n0 != 6) begin
            tests_failed++;
            $display("[TB] FAIL stream_count: got %0d results, required 6", n_out - n0);
        end
    endtask

    task automatic test_reset_midflight();
        logic seen;
        send(16'h3FB9, 16'h3FA2, 16'h3FEA, 3'b000);
        send(16'hBF80, 16'h4000, 16'hC000, 3'b000);
        send(16'h7F00, 16'h7F00, 16'h7F80, 3'b010);
        #1;
        rst_n = 1'b0;
        #1;
        sb.delete();
        tests_run += 2;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_out_valid: got %b, required 0", bus.out_valid);
        end
        if (bus.c !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL midreset_c: got %h, required 0000", bus.c);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1)
                seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_ghost_output: got out_valid=1, required 0");
        end
        send(16'h3FC1, 16'h3FC1, C_3FC1_SQ, 3'b000);
        measure_latency("post_reset");
        drain("post_reset");
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bf16_mul_pipe.md
Name: bf16_mul_pipe

Overview:
- 3-stage pipelined bfloat16 multiplier; the product stage of the MAC, directly upstream of bfloat_add_sub.
- Output c feeds the adder's a operand; the adder runs with cntl=0 to accumulate.
- Valid/ready handshake on both sides so the MAC controller can stall the product stream.

Parameters:
- EXP_W, 8, exponent width (bias = 2^(EXP_W-1)-1 = 127).
- MAN_W, 7, stored mantissa width. Total word width = 1+EXP_W+MAN_W = 16.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands a/b valid
- in_ready  out  1  stage 1 can accept this cycle
- a  in  16  bf16 multiplicand {sign, exp[7:0], man[6:0]}
- b  in  16  bf16 multiplier
- out_valid  out  1  c/flags valid
- out_ready  in  1  downstream accepts this cycle
- c  out  16  bf16 product
- flags  out  3  {nan_invalid, overflow, underflow}, aligned with c

Behaviour:
- Reset: all stage valids=0; out_valid=0; c=16'h0000; flags=3'b000; in_ready=1 after reset release.
- Global stall: adv = !out_valid || out_ready. in_ready = adv. All stages load only when adv=1; a bubble also advances.
- Transfer on in_valid&&in_ready; output consumed on out_valid&&out_ready. c/flags hold stable while out_valid && !out_ready.
- Latency: exactly 3 cycles from input transfer to out_valid with no stall. Throughput: 1 per cycle.
- S1 (unpack):
  - sign = a[15]^b[15].
  - Classify each operand as zero (exp==0, subnormals flushed), inf (exp==255, man==0) or nan (exp==255, man!=0).
  - Signed 10-bit esum = ea+eb-127.
  - Significands {1,man} (8 bits).
- S2 (multiply): 8x8 -> 16-bit product p; carry class/sign/esum forward.
- S3 (normalize/round/pack), via sub-module:
  - If p[15]: mantissa = p[14:8], guard = p[7], sticky = |p[6:0], esum+1.
  - Else: mantissa = p[13:7], guard = p[6], sticky = |p[5:0].
  - Rounding per optional feature. A mantissa carry-out after rounding sets mantissa=0 and esum+1.
  - Final esum >= 255: c = {sign, 8'hFF, 7'h0}, overflow=1.
  - Final esum <= 0: c = {sign, 15'h0} (flush to zero), underflow=1.
- Specials (precedence over arithmetic):
  - Any nan, or inf x zero: c = 16'h7FC0, nan_invalid=1.
  - inf x finite: signed inf.
  - zero x finite: signed zero, no flags.
- Reset asserted mid-operation: in-flight results are discarded, valids clear asynchronously, and no partial output is presented.

Optional Feature:
- BF16_MUL_RNE_EN defined: round-to-nearest-even. Increment when guard && (sticky || mantissa[0]).
- Undefined: truncate (guard/sticky ignored), and the rounding adder is removed.
- Special-case handling, overflow and flush-to-zero are identical in both builds.

Decomposition:
- Shared package bf16_pkg:
  - typedef packed struct bf16_t {sign, exp[7:0], man[6:0]}.
  - Constants: BF16_BIAS=127, BF16_QNAN=16'h7FC0, BF16_EXP_MAX=8'hFF.
  - Enum bf16_class_e {ZERO, NORM, INF, NAN}.
- One sub-module, bf16_round_pack: combinational S3 normalize/round/pack. It is reusable later by the adder rework.

Test Plan:
- a=16'h3FB9, b=16'h3FA2, in_valid=1, out_ready=1 -> 3 cycles later out_valid=1, c=16'h3FEA, flags=0 (both builds).
- a=b=16'h3FC1 -> c=16'h4012 with BF16_MUL_RNE_EN, c=16'h4011 without.
- a=16'hBF80, b=16'h4000 -> c=16'hC000. a=16'h7F80, b=16'h0000 -> c=16'h7FC0, flags=3'b100.
- a=b=16'h7F00 -> c=16'h7F80, flags=3'b010. a=b=16'h0080 -> c=16'h0000, flags=3'b001.
- Back-to-back stream of 6 vectors, out_ready low for cycles 4-6:
  - in_ready drops with out_ready.
  - c holds stable during the stall.
  - All 6 results appear in order with none lost or duplicated.
- Pulse rst_n low with 3 ops in flight -> out_valid=0 and c=0 immediately; first post-reset op appears after exactly 3 cycles.
